// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } lsu_state_t;

  typedef enum logic [1:0] {
    CAUSE_NONE       = 2'b00,
    CAUSE_MISALIGNED = 2'b01,
    CAUSE_TIMEOUT    = 2'b10,
    CAUSE_ILLEGAL    = 2'b11
  } lsu_cause_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: store-data replication, load-data lane select
// with sign/zero extension, and legality/alignment classification.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_off,
  input  logic        i_store,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata,
  output logic        o_misaligned,
  output logic        o_illegal
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic        w_f3_ok;

  // Pick the addressed byte/halfword from the returned word, then extend.
  always_comb begin
    w_byte = i_rdata[7:0];
    case (i_off)
      2'd0:    w_byte = i_rdata[7:0];
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      default: w_byte = i_rdata[31:24];
    endcase
    w_half  = i_off[1] ? i_rdata[31:16] : i_rdata[15:0];
    o_rdata = i_rdata;
    case (i_funct3)
      F3_B:    o_rdata = {{24{w_byte[7]}}, w_byte};
      F3_BU:   o_rdata = {24'h0, w_byte};
      F3_H:    o_rdata = {{16{w_half[15]}}, w_half};
      F3_HU:   o_rdata = {16'h0, w_half};
      default: o_rdata = i_rdata;
    endcase
  end

  // Replicate store data across every lane it could land in.
  always_comb begin
    o_wdata = i_wdata;
    case (i_funct3[1:0])
      2'b00:   o_wdata = {4{i_wdata[7:0]}};
      2'b01:   o_wdata = {2{i_wdata[15:0]}};
      default: o_wdata = i_wdata;
    endcase
  end

  // Classify the request; stores have no unsigned variants.
  always_comb begin
    w_f3_ok = (i_funct3 == F3_B)  || (i_funct3 == F3_H) || (i_funct3 == F3_W) ||
              (i_funct3 == F3_BU) || (i_funct3 == F3_HU);
    o_illegal    = !w_f3_ok || (i_store && i_funct3[2]);
    o_misaligned = ((i_funct3[1:0] == 2'b01) && i_off[0]) ||
                   ((i_funct3[1:0] == 2'b10) && (i_off != 2'b00));
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: accepts one execute-stage memory op, runs it on the
// dmem interface with a timeout, and returns a one-cycle writeback pulse.
// Handshake: a request is taken on a rising edge where ex_valid && ex_ready;
// ex_ready is high only in IDLE, and dmem_drdy is honoured only in ACCESS.
module lsu
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic        ex_load,
  input  logic        ex_store,
  input  logic [2:0]  ex_funct3,
  input  logic [31:0] ex_addr,
  input  logic [31:0] ex_wdata,
  output logic        ex_ready,
  output logic        stall,
  output logic        wb_valid,
  output logic [31:0] wb_rdata,
  output logic        wb_fault,
  output logic [1:0]  wb_cause,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic        dmem_read,
  output logic        dmem_write,
  output logic        dmem_rdu,
  output logic        dmem_byte,
  output logic        dmem_hwrd,
  output logic        dmem_wrd,
  input  logic        dmem_drdy,
  input  logic [31:0] dmem_rdata,
  output lsu_state_t  o_dbg_state
);

  lsu_state_t       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_funct3;
  logic             r_is_load;
  logic [31:0]      r_addr;
  logic [31:0]      r_wdata;
  logic             r_read, r_write, r_rdu, r_byte, r_hwrd, r_wrd;
  logic             r_wb_valid, r_wb_fault;
  logic [31:0]      r_wb_rdata;
  lsu_cause_t       r_wb_cause;

  logic [2:0]       w_f3;
  logic [1:0]       w_off;
  logic [31:0]      w_wdata_rep;
  logic [31:0]      w_rdata_ext;
  logic             w_misaligned;
  logic             w_illegal;
  logic             w_bad_kind;

  // In IDLE the lane logic classifies the incoming request; afterwards it
  // extracts read data for the registered request.
  assign w_f3       = (r_state == IDLE) ? ex_funct3 : r_funct3;
  assign w_off      = (r_state == IDLE) ? ex_addr[1:0] : r_addr[1:0];
  assign w_bad_kind = (ex_load == ex_store);

  lsu_align u_align (
    .i_funct3     (w_f3),
    .i_off        (w_off),
    .i_store      (ex_store),
    .i_wdata      (ex_wdata),
    .i_rdata      (dmem_rdata),
    .o_wdata      (w_wdata_rep),
    .o_rdata      (w_rdata_ext),
    .o_misaligned (w_misaligned),
    .o_illegal    (w_illegal)
  );

  // Request/response FSM with registered dmem strobes and writeback outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_funct3   <= 3'b000;
      r_is_load  <= 1'b0;
      r_addr     <= 32'h0;
      r_wdata    <= 32'h0;
      r_read     <= 1'b0;
      r_write    <= 1'b0;
      r_rdu      <= 1'b0;
      r_byte     <= 1'b0;
      r_hwrd     <= 1'b0;
      r_wrd      <= 1'b0;
      r_wb_valid <= 1'b0;
      r_wb_fault <= 1'b0;
      r_wb_rdata <= 32'h0;
      r_wb_cause <= CAUSE_NONE;
    end else begin
      case (r_state)
        IDLE: begin
          if (ex_valid) begin
            if (w_bad_kind || w_illegal) begin
              r_state    <= RESP;
              r_wb_valid <= 1'b1;
              r_wb_fault <= 1'b1;
              r_wb_cause <= CAUSE_ILLEGAL;
            end else if (w_misaligned) begin
              r_state    <= RESP;
              r_wb_valid <= 1'b1;
              r_wb_fault <= 1'b1;
              r_wb_cause <= CAUSE_MISALIGNED;
            end else begin
              r_state   <= ACCESS;
              r_cnt     <= '0;
              r_funct3  <= ex_funct3;
              r_is_load <= ex_load;
              r_addr    <= ex_addr;
              r_wdata   <= ex_store ? w_wdata_rep : 32'h0;
              r_read    <= ex_load;
              r_write   <= ex_store;
              r_rdu     <= ex_funct3[2];
              r_byte    <= (ex_funct3[1:0] == 2'b00);
              r_hwrd    <= (ex_funct3[1:0] == 2'b01);
              r_wrd     <= (ex_funct3[1:0] == 2'b10);
            end
          end
        end
        ACCESS: begin
          if (dmem_drdy || (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1))) begin
            r_state    <= RESP;
            r_read     <= 1'b0;
            r_write    <= 1'b0;
            r_rdu      <= 1'b0;
            r_byte     <= 1'b0;
            r_hwrd     <= 1'b0;
            r_wrd      <= 1'b0;
            r_wb_valid <= 1'b1;
            if (dmem_drdy) begin
              r_wb_rdata <= r_is_load ? w_rdata_ext : 32'h0;
            end else begin
              r_wb_fault <= 1'b1;
              r_wb_cause <= CAUSE_TIMEOUT;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        RESP: begin
          r_state    <= IDLE;
          r_wb_valid <= 1'b0;
          r_wb_fault <= 1'b0;
          r_wb_rdata <= 32'h0;
          r_wb_cause <= CAUSE_NONE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign ex_ready    = (r_state == IDLE);
  assign stall       = !ex_ready;
  assign wb_valid    = r_wb_valid;
  assign wb_rdata    = r_wb_rdata;
  assign wb_fault    = r_wb_fault;
  assign wb_cause    = r_wb_cause;
  assign dmem_addr   = r_addr;
  assign dmem_wdata  = r_wdata;
  assign dmem_read   = r_read;
  assign dmem_write  = r_write;
  assign dmem_rdu    = r_rdu;
  assign dmem_byte   = r_byte;
  assign dmem_hwrd   = r_hwrd;
  assign dmem_wrd    = r_wrd;
  assign o_dbg_state = r_state;

endmodule
